bisr_remap_ctrl: RTL and testbench



---
 rtl/bisr_remap_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_bisr_remap_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bisr_remap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bisr_remap_ctrl
// Description : Built-in self-repair remap controller. Learns faulty blocks
//               during BIST and steers mission accesses to a main bank or to
//               the allocated spare block, with registered outputs.
//               Optional table readback port: define BISR_TABLE_RD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bisr_remap_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int BLK_W   = 7,
    parameter int BANK_W  = 6,
    parameter int SPARE_N = 25,
    parameter int DATA_W  = 8
) (
    input  logic                             CLK,
    input  logic                             RSTN,
    input  logic                             BIST_EN,
    input  logic                             FAULT_VLD,
    input  logic [ADDR_W-1:0]                FAULT_ADDR,
    input  logic                             CLR,
    input  logic                             CE,
    input  logic                             CSB,
    input  logic                             WEB,
    input  logic                             OEB,
    input  logic [ADDR_W-1:0]                ADDR,
    input  logic [DATA_W-1:0]                IDATA,
    output logic                             MEM_CE,
    output logic [(1<<BANK_W)-1:0]           MEM_CSB,
    output logic [(1<<BANK_W)-1:0]           MEM_OEB,
    output logic                             MEM_WEB,
    output logic [ADDR_W-BANK_W-1:0]         MEM_ADDR,
    output logic [DATA_W-1:0]                MEM_IDATA,
    output logic                             SPARE_MEM_CE,
    output logic [SPARE_N-1:0]               SPARE_MEM_CSB,
    output logic [SPARE_N-1:0]               SPARE_MEM_OEB,
    output logic                             SPARE_MEM_WEB,
    output logic [BLK_W-1:0]                 SPARE_MEM_ADDR,
    output logic [DATA_W-1:0]                SPARE_MEM_IDATA,
    output logic [$clog2(SPARE_N+1)-1:0]     FAULT_CNT,
`ifdef BISR_TABLE_RD_EN
    input  logic [$clog2(SPARE_N)-1:0]       TBL_IDX,
    output logic                             TBL_VLD,
    output logic [ADDR_W-BLK_W-1:0]          TBL_BLK,
`endif
    output logic                             REPAIR_FAIL
);

    localparam int c_BI_W  = ADDR_W - BLK_W;
    localparam int c_NB    = 1 << BANK_W;
    localparam int c_MA_W  = ADDR_W - BANK_W;
    localparam int c_CNT_W = $clog2(SPARE_N + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SPARE_N);

    // Fault table
    logic [SPARE_N-1:0]   r_tbl_vld;
    logic [c_BI_W-1:0]    r_tbl_blk [SPARE_N];
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_fail;

    logic [c_BI_W-1:0]    w_fault_bi;
    logic [c_BI_W-1:0]    w_acc_bi;
    logic [SPARE_N-1:0]   w_fault_match;
    logic [SPARE_N-1:0]   w_acc_match;
    logic                 w_fault_dup;
    logic                 w_acc_hit;
    logic [BANK_W-1:0]    w_bank;
    logic [c_NB-1:0]      w_bank_oh;
    logic                 w_unused_ok;

    assign w_fault_bi  = FAULT_ADDR[ADDR_W-1:BLK_W];
    assign w_acc_bi    = ADDR[ADDR_W-1:BLK_W];
    assign w_bank      = ADDR[ADDR_W-1 -: BANK_W];
    assign w_bank_oh   = {{(c_NB-1){1'b0}}, 1'b1} << w_bank;
    assign w_unused_ok = ^FAULT_ADDR[BLK_W-1:0];

    generate
        for (genvar k = 0; k < SPARE_N; k++) begin : g_match
            assign w_fault_match[k] = r_tbl_vld[k] && (r_tbl_blk[k] == w_fault_bi);
            assign w_acc_match[k]   = r_tbl_vld[k] && (r_tbl_blk[k] == w_acc_bi);
        end
    endgenerate

    assign w_fault_dup = |w_fault_match;
    assign w_acc_hit   = |w_acc_match;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_tbl_vld <= '0;
            for (int k = 0; k < SPARE_N; k++) r_tbl_blk[k] <= '0;
            r_cnt     <= '0;
            r_fail    <= 1'b0;
        end else if (CLR) begin
            r_tbl_vld <= '0;
            for (int k = 0; k < SPARE_N; k++) r_tbl_blk[k] <= '0;
            r_cnt     <= '0;
            r_fail    <= 1'b0;
        end else if (BIST_EN && FAULT_VLD && !w_fault_dup) begin
            if (r_cnt != c_CNT_MAX) begin
                for (int k = 0; k < SPARE_N; k++) begin
                    if (c_CNT_W'(k) == r_cnt) begin
                        r_tbl_vld[k] <= 1'b1;
                        r_tbl_blk[k] <= w_fault_bi;
                    end
                end
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_fail <= 1'b1;
            end
        end
    end

    assign FAULT_CNT   = r_cnt;
    assign REPAIR_FAIL = r_fail;

    // Access steering; a match vector is one-hot by construction
    logic                 r_mem_ce;
    logic [c_NB-1:0]      r_mem_csb;
    logic [c_NB-1:0]      r_mem_oeb;
    logic                 r_mem_web;
    logic [c_MA_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_idata;
    logic                 r_sp_ce;
    logic [SPARE_N-1:0]   r_sp_csb;
    logic [SPARE_N-1:0]   r_sp_oeb;
    logic                 r_sp_web;
    logic [BLK_W-1:0]     r_sp_addr;
    logic [DATA_W-1:0]    r_sp_idata;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_mem_ce    <= 1'b0;
            r_mem_csb   <= '1;
            r_mem_oeb   <= '1;
            r_mem_web   <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_idata <= '0;
            r_sp_ce     <= 1'b0;
            r_sp_csb    <= '1;
            r_sp_oeb    <= '1;
            r_sp_web    <= 1'b1;
            r_sp_addr   <= '0;
            r_sp_idata  <= '0;
        end else begin
            r_mem_ce    <= 1'b0;
            r_mem_csb   <= '1;
            r_mem_oeb   <= '1;
            r_mem_web   <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_idata <= '0;
            r_sp_ce     <= 1'b0;
            r_sp_csb    <= '1;
            r_sp_oeb    <= '1;
            r_sp_web    <= 1'b1;
            r_sp_addr   <= '0;
            r_sp_idata  <= '0;
            if (!BIST_EN) begin
                if (w_acc_hit) begin
                    r_sp_ce    <= CE;
                    r_sp_csb   <= {SPARE_N{CSB}} | ~w_acc_match;
                    r_sp_oeb   <= {SPARE_N{OEB}} | ~w_acc_match;
                    r_sp_web   <= WEB;
                    r_sp_addr  <= ADDR[BLK_W-1:0];
                    r_sp_idata <= IDATA;
                end else begin
                    r_mem_ce    <= CE;
                    r_mem_csb   <= {c_NB{CSB}} | ~w_bank_oh;
                    r_mem_oeb   <= {c_NB{OEB}} | ~w_bank_oh;
                    r_mem_web   <= WEB;
                    r_mem_addr  <= ADDR[c_MA_W-1:0];
                    r_mem_idata <= IDATA;
                end
            end
        end
    end

    assign MEM_CE          = r_mem_ce;
    assign MEM_CSB         = r_mem_csb;
    assign MEM_OEB         = r_mem_oeb;
    assign MEM_WEB         = r_mem_web;
    assign MEM_ADDR        = r_mem_addr;
    assign MEM_IDATA       = r_mem_idata;
    assign SPARE_MEM_CE    = r_sp_ce;
    assign SPARE_MEM_CSB   = r_sp_csb;
    assign SPARE_MEM_OEB   = r_sp_oeb;
    assign SPARE_MEM_WEB   = r_sp_web;
    assign SPARE_MEM_ADDR  = r_sp_addr;
    assign SPARE_MEM_IDATA = r_sp_idata;

`ifdef BISR_TABLE_RD_EN
    logic              r_rd_vld;
    logic [c_BI_W-1:0] r_rd_blk;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rd_vld <= 1'b0;
            r_rd_blk <= '0;
        end else begin
            r_rd_vld <= 1'b0;
            r_rd_blk <= '0;
            for (int k = 0; k < SPARE_N; k++) begin
                if ($bits(TBL_IDX)'(k) == TBL_IDX) begin
                    r_rd_vld <= r_tbl_vld[k];
                    r_rd_blk <= r_tbl_blk[k];
                end
            end
        end
    end

    assign TBL_VLD = r_rd_vld;
    assign TBL_BLK = r_rd_blk;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bisr_remap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bisr_remap_ctrl
// Description : Directed self-checking bench for bisr_remap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bisr_remap_ctrl;

    localparam int c_ADDR_W  = 16;
    localparam int c_BLK_W   = 7;
    localparam int c_BANK_W  = 6;
    localparam int c_SPARE_N = 25;
    localparam int c_DATA_W  = 8;
    localparam int c_NB      = 1 << c_BANK_W;
    localparam int c_CNT_W   = $clog2(c_SPARE_N + 1);

    logic                        CLK = 1'b0;
    logic                        RSTN;
    logic                        BIST_EN;
    logic                        FAULT_VLD;
    logic [c_ADDR_W-1:0]         FAULT_ADDR;
    logic                        CLR;
    logic                        CE;
    logic                        CSB;
    logic                        WEB;
    logic                        OEB;
    logic [c_ADDR_W-1:0]         ADDR;
    logic [c_DATA_W-1:0]         IDATA;
    logic                        MEM_CE;
    logic [c_NB-1:0]             MEM_CSB;
    logic [c_NB-1:0]             MEM_OEB;
    logic                        MEM_WEB;
    logic [c_ADDR_W-c_BANK_W-1:0] MEM_ADDR;
    logic [c_DATA_W-1:0]         MEM_IDATA;
    logic                        SPARE_MEM_CE;
    logic [c_SPARE_N-1:0]        SPARE_MEM_CSB;
    logic [c_SPARE_N-1:0]        SPARE_MEM_OEB;
    logic                        SPARE_MEM_WEB;
    logic [c_BLK_W-1:0]          SPARE_MEM_ADDR;
    logic [c_DATA_W-1:0]         SPARE_MEM_IDATA;
    logic [c_CNT_W-1:0]          FAULT_CNT;
    logic                        REPAIR_FAIL;
`ifdef BISR_TABLE_RD_EN
    logic [$clog2(c_SPARE_N)-1:0] TBL_IDX;
    logic                         TBL_VLD;
    logic [c_ADDR_W-c_BLK_W-1:0]  TBL_BLK;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bisr_remap_ctrl #(
        .ADDR_W (c_ADDR_W),
        .BLK_W  (c_BLK_W),
        .BANK_W (c_BANK_W),
        .SPARE_N(c_SPARE_N),
        .DATA_W (c_DATA_W)
    ) dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .BIST_EN        (BIST_EN),
        .FAULT_VLD      (FAULT_VLD),
        .FAULT_ADDR     (FAULT_ADDR),
        .CLR            (CLR),
        .CE             (CE),
        .CSB            (CSB),
        .WEB            (WEB),
        .OEB            (OEB),
        .ADDR           (ADDR),
        .IDATA          (IDATA),
        .MEM_CE         (MEM_CE),
        .MEM_CSB        (MEM_CSB),
        .MEM_OEB        (MEM_OEB),
        .MEM_WEB        (MEM_WEB),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_IDATA      (MEM_IDATA),
        .SPARE_MEM_CE   (SPARE_MEM_CE),
        .SPARE_MEM_CSB  (SPARE_MEM_CSB),
        .SPARE_MEM_OEB  (SPARE_MEM_OEB),
        .SPARE_MEM_WEB  (SPARE_MEM_WEB),
        .SPARE_MEM_ADDR (SPARE_MEM_ADDR),
        .SPARE_MEM_IDATA(SPARE_MEM_IDATA),
        .FAULT_CNT      (FAULT_CNT),
`ifdef BISR_TABLE_RD_EN
        .TBL_IDX        (TBL_IDX),
        .TBL_VLD        (TBL_VLD),
        .TBL_BLK        (TBL_BLK),
`endif
        .REPAIR_FAIL    (REPAIR_FAIL)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_NB-1:0] bank_cs(input int b);
        logic [c_NB-1:0] m;
        m    = '1;
        m[b] = 1'b0;
        return m;
    endfunction

    function automatic logic [c_SPARE_N-1:0] spare_cs(input int k);
        logic [c_SPARE_N-1:0] m;
        m    = '1;
        m[k] = 1'b0;
        return m;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fault(input logic [c_ADDR_W-1:0] a);
        FAULT_VLD  = 1'b1;
        FAULT_ADDR = a;
        tick();
        FAULT_VLD  = 1'b0;
    endtask

    task automatic access(input logic [c_ADDR_W-1:0] a, input logic csb_i,
                          input logic web_i, input logic oeb_i,
                          input logic [c_DATA_W-1:0] d);
        CE    = 1'b1;
        CSB   = csb_i;
        WEB   = web_i;
        OEB   = oeb_i;
        ADDR  = a;
        IDATA = d;
        tick();
        CE    = 1'b0;
        CSB   = 1'b1;
        WEB   = 1'b1;
        OEB   = 1'b1;
        ADDR  = '0;
        IDATA = '0;
    endtask

    initial begin
        RSTN = 1'b0; BIST_EN = 1'b0; FAULT_VLD = 1'b0; FAULT_ADDR = '0; CLR = 1'b0;
        CE = 1'b0; CSB = 1'b1; WEB = 1'b1; OEB = 1'b1; ADDR = '0; IDATA = '0;
`ifdef BISR_TABLE_RD_EN
        TBL_IDX = '0;
`endif
        tick(); tick();
        chk("rst_mem_csb",   MEM_CSB, {c_NB{1'b1}});
        chk("rst_mem_oeb",   MEM_OEB, {c_NB{1'b1}});
        chk("rst_sp_csb",    SPARE_MEM_CSB, {c_SPARE_N{1'b1}});
        chk("rst_mem_ce",    MEM_CE, 0);
        chk("rst_mem_web",   MEM_WEB, 1);
        chk("rst_mem_addr",  MEM_ADDR, 0);
        chk("rst_cnt",       FAULT_CNT, 0);
        chk("rst_fail",      REPAIR_FAIL, 0);
        RSTN = 1'b1;
        tick();

        // Mission write to an unrepaired address: bank 4
        access(16'h1234, 1'b0, 1'b0, 1'b1, 8'hA5);
        chk("w_mem_csb",   MEM_CSB, bank_cs(4));
        chk("w_mem_oeb",   MEM_OEB, {c_NB{1'b1}});
        chk("w_mem_addr",  MEM_ADDR, 10'h234);
        chk("w_mem_idata", MEM_IDATA, 8'hA5);
        chk("w_mem_web",   MEM_WEB, 0);
        chk("w_mem_ce",    MEM_CE, 1);
        chk("w_sp_csb",    SPARE_MEM_CSB, {c_SPARE_N{1'b1}});
        chk("w_sp_ce",     SPARE_MEM_CE, 0);

        // Learn blocks 9 and 2, then read block 2 from spare 1
        BIST_EN = 1'b1;
        fault(16'h0480);
        fault(16'h0100);
        BIST_EN = 1'b0;
        access(16'h0105, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("r_sp_csb",   SPARE_MEM_CSB, spare_cs(1));
        chk("r_sp_oeb",   SPARE_MEM_OEB, spare_cs(1));
        chk("r_sp_addr",  SPARE_MEM_ADDR, 7'h05);
        chk("r_sp_ce",    SPARE_MEM_CE, 1);
        chk("r_mem_csb",  MEM_CSB, {c_NB{1'b1}});
        chk("r_mem_ce",   MEM_CE, 0);
        chk("r_cnt",      FAULT_CNT, 2);
`ifdef BISR_TABLE_RD_EN
        TBL_IDX = 5'd1;
        tick();
        chk("tbl1_vld", TBL_VLD, 1);
        chk("tbl1_blk", TBL_BLK, 9'h002);
        TBL_IDX = 5'd30;
        tick();
        chk("tbl30_vld", TBL_VLD, 0);
        chk("tbl30_blk", TBL_BLK, 0);
`endif

        // Arrays stay idle while BIST owns them
        BIST_EN = 1'b1;
        access(16'h0105, 1'b0, 1'b0, 1'b0, 8'h11);
        chk("bist_sp_csb",  SPARE_MEM_CSB, {c_SPARE_N{1'b1}});
        chk("bist_mem_csb", MEM_CSB, {c_NB{1'b1}});
        chk("bist_sp_ce",   SPARE_MEM_CE, 0);

        // Clear, then back-to-back pulses within one block allocate once
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("clr_cnt", FAULT_CNT, 0);
        fault(16'h0480);
        fault(16'h04FF);
        chk("dup_cnt", FAULT_CNT, 1);
        BIST_EN = 1'b0;
        access(16'h04FF, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("dup_sp_csb",  SPARE_MEM_CSB, spare_cs(0));
        chk("dup_sp_addr", SPARE_MEM_ADDR, 7'h7F);
        chk("dup_mem_csb", MEM_CSB, {c_NB{1'b1}});

        // Faults outside BIST are ignored
        fault(16'h0100);
        chk("nobist_cnt", FAULT_CNT, 1);

        // Clear wins over a simultaneous fault pulse
        BIST_EN    = 1'b1;
        CLR        = 1'b1;
        FAULT_VLD  = 1'b1;
        FAULT_ADDR = 16'h0200;
        tick();
        CLR = 1'b0; FAULT_VLD = 1'b0;
        chk("clrpri_cnt", FAULT_CNT, 0);

        // Fill the pool, then overflow
        for (int i = 0; i < c_SPARE_N; i++) fault(16'(i << c_BLK_W));
        chk("full_cnt",  FAULT_CNT, 25);
        chk("full_fail", REPAIR_FAIL, 0);
        fault(16'(25 << c_BLK_W));
        chk("ovf_cnt",  FAULT_CNT, 25);
        chk("ovf_fail", REPAIR_FAIL, 1);
        BIST_EN = 1'b0;
        access(16'h0C80, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("ovf_mem_csb",  MEM_CSB, bank_cs(3));
        chk("ovf_mem_addr", MEM_ADDR, 10'h080);
        chk("ovf_sp_csb",   SPARE_MEM_CSB, {c_SPARE_N{1'b1}});
        access(16'h0C05, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("last_sp_csb",  SPARE_MEM_CSB, spare_cs(24));
        chk("last_sp_addr", SPARE_MEM_ADDR, 7'h05);
        chk("fail_sticky",  REPAIR_FAIL, 1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("clr2_cnt",  FAULT_CNT, 0);
        chk("clr2_fail", REPAIR_FAIL, 0);

        // Reset in the middle of a spare access
        BIST_EN = 1'b1;
        fault(16'h0100);
        BIST_EN = 1'b0;
        access(16'h0105, 1'b0, 1'b0, 1'b1, 8'h3C);
        chk("pre_sp_idata", SPARE_MEM_IDATA, 8'h3C);
        #2 RSTN = 1'b0;
        #1;
        chk("mid_sp_csb",   SPARE_MEM_CSB, {c_SPARE_N{1'b1}});
        chk("mid_sp_ce",    SPARE_MEM_CE, 0);
        chk("mid_sp_web",   SPARE_MEM_WEB, 1);
        chk("mid_sp_idata", SPARE_MEM_IDATA, 0);
        chk("mid_cnt",      FAULT_CNT, 0);
        tick();
        RSTN = 1'b1;
        access(16'h0105, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("post_mem_csb", MEM_CSB, bank_cs(0));
        chk("post_sp_csb",  SPARE_MEM_CSB, {c_SPARE_N{1'b1}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
